// File: rtl/mux_gate_scheduler.sv
// mux_gate_scheduler
//   Two-requester scheduler that time-shares one 1-bit mux-based NAND/NOR
//   cell. Each granted request runs a WIDTH-bit bitwise NAND (op=0) or
//   NOR (op=1) bit-serially, LSB first, one bit per clock. The result is
//   tagged with the served requester and announced by a one-cycle done pulse.
//
//   Build option: define MUX_GATE_SCHED_RR_EN for round-robin tie-break on
//   a last_id register; leave it undefined for fixed priority (requester 0
//   wins ties, last_id not built).
//
//   Ports:
//     clk              rising-edge clock
//     rst              asynchronous active-high reset
//     req0/req1        requests, sampled only while idle
//     op0/op1          0 = NAND, 1 = NOR
//     a0,b0/a1,b1      WIDTH-bit operands, held stable while req is high
//     gnt0/gnt1        one-cycle grant pulse, operands captured
//     busy             scheduler not idle
//     done             one-cycle completion pulse
//     done_id          requester served by the completing operation
//     result           result of the last completed operation

// Universal gate cell built from 2:1 muxes selected by a.
module mux_nand_nor_cell (
  input  logic a,
  input  logic b,
  output logic nand_out,
  output logic nor_out
);
  assign nand_out = a ? ~b   : 1'b1;
  assign nor_out  = a ? 1'b0 : ~b;
endmodule

module mux_gate_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             op_q;
  logic             id_q;
  logic [WIDTH-1:0] result_q, result_nxt;
  logic [WIDTH-1:0] result_r;
  logic             done_id_r;
  logic             any_req;
  logic             win1;
  logic             cell_nand, cell_nor, cell_bit;

  assign any_req = req0 | req1;

`ifdef MUX_GATE_SCHED_RR_EN
  logic last_id;
  // On a tie the requester that was not served last wins.
  assign win1 = req1 & (~req0 | ~last_id);
`else
  assign win1 = req1 & ~req0;
`endif

  mux_nand_nor_cell u_cell (
    .a        (a_q[cnt]),
    .b        (b_q[cnt]),
    .nand_out (cell_nand),
    .nor_out  (cell_nor)
  );

  assign cell_bit = op_q ? cell_nor : cell_nand;

  always_comb begin
    result_nxt      = result_q;
    result_nxt[cnt] = cell_bit;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from registers only. The grant pulse is the single RUN
  // cycle with cnt==0, i.e. the cycle right after the sampling edge.
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    gnt0    = (state == RUN) && (cnt == '0) && !id_q;
    gnt1    = (state == RUN) && (cnt == '0) &&  id_q;
    result  = result_r;
    done_id = done_id_r;
  end

  // Operand capture and bit-serial datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
      id_q      <= 1'b0;
      result_q  <= '0;
      result_r  <= '0;
      done_id_r <= 1'b0;
`ifdef MUX_GATE_SCHED_RR_EN
      last_id   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            a_q  <= win1 ? a1  : a0;
            b_q  <= win1 ? b1  : b0;
            op_q <= win1 ? op1 : op0;
            id_q <= win1;
            cnt  <= '0;
`ifdef MUX_GATE_SCHED_RR_EN
            last_id <= win1;
`endif
          end
        end
        RUN: begin
          result_q <= result_nxt;
          if (cnt == LAST) begin
            cnt       <= '0;
            result_r  <= result_nxt;
            done_id_r <= id_q;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
